// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg: shared defaults and the width helper used by the register pipe.
package reg_pipe_pkg;
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;
    localparam logic [63:0] DEFAULT_RESET_VAL = '0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one data+valid register with async reset, sync clear and enable.
module pipe_stage #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            q       <= RESET_VAL;
            q_valid <= 1'b0;
        end else if (clear) begin
            q       <= RESET_VAL;
            q_valid <= 1'b0;
        end else if (en) begin
            q       <= d;
            q_valid <= d_valid;
        end
    end
endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage enabled shift pipe with per-word valid bits and an occupancy count.
module reg_pipe import reg_pipe_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = DEFAULT_RESET_VAL[WIDTH-1:0]
) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         clear,
    input  logic [WIDTH-1:0]             d,
    input  logic                         d_valid,
    output logic [WIDTH-1:0]             q,
    output logic                         q_valid,
    output logic [DEPTH*WIDTH-1:0]       taps,
    output logic [clog2(DEPTH+1)-1:0]    count
);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] sd;
        logic             sv;
        if (i == 0) begin : g_head
            assign sd = d;
            assign sv = d_valid;
        end else begin : g_tail
            assign sd = data[i-1];
            assign sv = valid[i-1];
        end
        pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
            .clock   (clock),
            .rst     (rst),
            .en      (en),
            .clear   (clear),
            .d       (sd),
            .d_valid (sv),
            .q       (data[i]),
            .q_valid (valid[i])
        );
        assign taps[i*WIDTH +: WIDTH] = data[i];
    end

    assign q       = data[DEPTH-1];
    assign q_valid = valid[DEPTH-1];

    // Tracked incrementally so it matches the popcount of valid without an adder tree.
    always_ff @(posedge clock or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (en)
            count <= count + CW'(d_valid) - CW'(q_valid);
    end
endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: directed and random checks of reg_pipe (DEPTH=4 and DEPTH=1) against a queue model.
module tb_reg_pipe;
    logic        clock = 1'b0;
    logic        rst;
    logic        en;
    logic        clear;
    logic [7:0]  d;
    logic        d_valid;
    logic [7:0]  q, q1;
    logic        q_valid, q1_valid;
    logic [31:0] taps;
    logic [7:0]  taps1;
    logic [2:0]  count;
    logic [0:0]  count1;

    int checks = 0;
    int errors = 0;

    logic [8:0] mq[$];
    logic [8:0] m1;

    reg_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
        .clock(clock), .rst(rst), .en(en), .clear(clear), .d(d), .d_valid(d_valid),
        .q(q), .q_valid(q_valid), .taps(taps), .count(count)
    );

    reg_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) dut1 (
        .clock(clock), .rst(rst), .en(en), .clear(clear), .d(d), .d_valid(d_valid),
        .q(q1), .q_valid(q1_valid), .taps(taps1), .count(count1)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        repeat (4) mq.push_back(9'h000);
        m1 = 9'h000;
    endtask

    task automatic check_model();
        logic [31:0] et;
        int ec;
        et = '0;
        ec = 0;
        for (int i = 0; i < 4; i++) begin
            et[i*8 +: 8] = mq[i][7:0];
            ec += int'(mq[i][8]);
        end
        chk("q", q, mq[3][7:0]);
        chk("q_valid", q_valid, mq[3][8]);
        chk("taps", taps, et);
        chk("count", count, ec);
        chk("q1", q1, m1[7:0]);
        chk("q1_valid", q1_valid, m1[8]);
        chk("taps1", taps1, m1[7:0]);
        chk("count1", count1, m1[8]);
    endtask

    task automatic step(input logic e, input logic c, input logic [7:0] dd, input logic dv);
        en = e;
        clear = c;
        d = dd;
        d_valid = dv;
        @(posedge clock);
        if (!rst) begin
            if (c) begin
                model_reset();
            end else if (e) begin
                mq.push_front({dv, dd});
                void'(mq.pop_back());
                m1 = {dv, dd};
            end
        end
        #1;
        check_model();
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        en = 1'b1;
        clear = 1'b0;
        d = 8'hFF;
        d_valid = 1'b1;
        #1;
        chk("rst_q", q, 8'h00);
        chk("rst_q_valid", q_valid, 1'b0);
        chk("rst_count", count, 3'd0);
        repeat (3) step(1'b1, 1'b0, 8'hFF, 1'b1);
        rst = 1'b0;

        // fill with 01..04
        for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, 8'(k), 1'b1);
        chk("fill_q", q, 8'h01);
        chk("fill_q_valid", q_valid, 1'b1);
        chk("fill_count", count, 3'd4);

        // enable toggling 1,0,0,1
        step(1'b1, 1'b0, 8'h05, 1'b1);
        chk("hold_q_a", q, 8'h02);
        step(1'b0, 1'b0, 8'h06, 1'b0);
        chk("hold_q_b", q, 8'h02);
        chk("hold_taps_b", taps, 32'h02030405);
        step(1'b0, 1'b0, 8'h07, 1'b0);
        chk("hold_count_c", count, 3'd4);
        step(1'b1, 1'b0, 8'h08, 1'b1);
        chk("hold_q_d", q, 8'h03);

        // clear has priority over en
        step(1'b1, 1'b1, 8'hAA, 1'b1);
        chk("clr_taps", taps, 32'h0);
        chk("clr_q_valid", q_valid, 1'b0);
        chk("clr_count", count, 3'd0);

        // alternating valid pattern
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, 8'($urandom), (k % 2) == 0);
            if (k >= 3) chk("alt_count", count, 3'd2);
            if (k >= 3) chk("alt_q_valid", q_valid, ((k - 3) % 2) == 0);
        end

        for (int k = 0; k < 300; k++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 8'($urandom), 1'($urandom));

        // asynchronous reset mid-cycle with count=3
        step(1'b1, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h11, 1'b1);
        step(1'b1, 1'b0, 8'h22, 1'b1);
        step(1'b1, 1'b0, 8'h33, 1'b1);
        chk("pre_rst_count", count, 3'd3);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_count", count, 3'd0);
        chk("async_q_valid", q_valid, 1'b0);
        chk("async_taps", taps, 32'h0);
        step(1'b1, 1'b0, 8'h44, 1'b1);
        #2;
        rst = 1'b0;
        step(1'b1, 1'b0, 8'h5A, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
        chk("post_rst_q", q, 8'h5A);
        chk("post_rst_q_valid", q_valid, 1'b1);
        chk("post_rst_count", count, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_pipe.md
REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data word width in bits (1..64).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of register stages (1..32).
REQ-003 The block SHALL have parameter RESET_VAL, default 0, giving the WIDTH-bit value loaded into every data stage on reset or clear.
REQ-004 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit, advance enable: high shifts the pipe one stage, low holds all state.
REQ-007 The block SHALL have port clear, input, 1 bit, synchronous active-high flush.
REQ-008 The block SHALL have port d, input, WIDTH bits, data entering stage 0.
REQ-009 The block SHALL have port d_valid, input, 1 bit, qualifier for d.
REQ-010 The block SHALL have port q, output, WIDTH bits, contents of stage DEPTH-1.
REQ-011 The block SHALL have port q_valid, output, 1 bit, valid bit of stage DEPTH-1.
REQ-012 The block SHALL have port taps, output, DEPTH*WIDTH bits, all stage contents, with stage i at bits [i*WIDTH +: WIDTH].
REQ-013 The block SHALL have port count, output, clog2(DEPTH+1) bits, number of stages currently holding a valid word.

Function
REQ-014 The block SHALL implement each stage as a WIDTH-bit data register plus a 1-bit valid register.
REQ-015 With en=1 and clear=0, the block SHALL, on each rising clock edge, load stage0 from d/d_valid and stage i from stage i-1 for i=1..DEPTH-1.
REQ-016 With en=0 and clear=0, the block SHALL hold all data, valid and count unchanged.
REQ-017 Latency SHALL be exactly DEPTH enabled edges from d sampled to the same value on q; disabled cycles add no shift.
REQ-018 The block SHALL shift invalid words (d_valid=0) through like valid ones, with their valid bit 0; data bits SHALL still be captured.
REQ-019 With clear=1 on an edge, the block SHALL set all data stages to RESET_VAL, all valid bits to 0 and count to 0, regardless of en; clear SHALL have priority over en.
REQ-020 On an enabled edge, count SHALL update as count + d_valid - q_valid (pre-edge values); simultaneous entry and exit SHALL leave count unchanged.
REQ-021 count SHALL never exceed DEPTH nor underflow below 0, and SHALL always equal the population count of the valid bits.
REQ-022 q, q_valid and taps SHALL be driven directly from registers with no combinational path from d, en or clear.
REQ-023 With DEPTH=1, the block SHALL behave as a single enabled, clearable register with latency 1 and count in {0,1}.

Reset
REQ-024 When rst=1, the block SHALL immediately, without waiting for a clock edge, force all data stages to RESET_VAL, all valid bits to 0 and count to 0.
REQ-025 Assertion of rst mid-operation SHALL discard all in-flight words; no partial shift SHALL occur on an edge coinciding with rst=1.
REQ-026 After rst deasserts, the first edge SHALL act per REQ-015, REQ-016 and REQ-019.
REQ-027 Outputs after reset SHALL be q=RESET_VAL, q_valid=0, taps=all RESET_VAL and count=0.

Structure
REQ-028 A shared package SHALL hold a clog2 function for the count width and the default WIDTH, DEPTH and RESET_VAL constants.
REQ-029 The block SHALL use one sub-module, pipe_stage (parameter WIDTH, RESET_VAL; ports clock, rst, en, clear, d, d_valid, q, q_valid), instantiated DEPTH times by a generate loop.
REQ-030 The count logic SHALL live in reg_pipe, not in pipe_stage.

Verification
REQ-031 Verification SHALL apply rst=1 with clock running and en=1, d=8'hFF -> q=8'h00, q_valid=0, count=0 immediately and for as long as rst is held.
REQ-032 Verification SHALL apply WIDTH=8, DEPTH=4, en=1 and d_valid=1 with d=8'h01,02,03,04 on consecutive edges -> q=8'h01 with q_valid=1 after the 4th edge, and count=4.
REQ-033 Verification SHALL, with the pipe full and en toggled 1,0,0,1, require q to advance only on the two enabled edges, with taps and count unchanged while en=0.
REQ-034 Verification SHALL, with the pipe full (count=4), drive clear=1 and en=1 with d=8'hAA, d_valid=1 -> next edge: taps all 8'h00, q_valid=0, count=0.
REQ-035 Verification SHALL drive the alternating d_valid pattern 1,0,1,0 over 8 enabled edges -> count holds at 2 once the pipe is full, and q_valid follows the input pattern delayed by 4 edges.
REQ-036 Verification SHALL assert rst asynchronously between edges while count=3 -> count=0 and q_valid=0 before the next edge; after release, the first valid word reaches q after 4 enabled edges.
